hs4_rx_fifo: RTL and testbench
==============================

Name: hs4_rx_fifo

Overview:
- Receiving end of the two-flop, four-phase req/ack data crossing.
- Synchronises the sender's req, captures bundled input_rx, returns ack, and queues words in a small FIFO.
- Words are presented to the local consumer with a show-ahead valid/read interface.
- Backpressure: ack is withheld while the FIFO is full, which stalls the sender without losing data.

Parameters:
DATA_WIDTH, `DATA_WIDTHS (8), width of the data word
DEPTH, 4, FIFO entries; power of two, at least 2
SYNC_STAGES, 2, flops in the req synchroniser; at least 2

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-high
req  input  1  four-phase request from the sender; asynchronous to clk
input_rx  input  DATA_WIDTH  bundled data; sender holds it stable from req rise until it sees ack rise
ack  output  1  four-phase acknowledge to the sender; registered
output_rx  output  DATA_WIDTH  FIFO head word (show-ahead)
d  output  1  data valid: FIFO not empty
rd  input  1  consumer pop; honoured only when d=1
full  output  1  FIFO holds DEPTH words
count  output  clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (sync, wins over all other inputs):
  - ack=0, d=0, full=0, count=0, output_rx=0.
  - Synchroniser flops cleared.
  - FSM goes to IDLE; read and write pointers cleared.
- Synchroniser:
  - req_s is req after SYNC_STAGES flops.
  - Only req_s is used internally; raw req never feeds logic.
- FSM, two states; encodings live in def.v:
  - IDLE (ack=0):
    - If req_s=1 and full=0: write input_rx at wr_ptr, set ack<=1, go to WAIT_LOW.
    - If req_s=1 and full=1: remain in IDLE with ack=0 (backpressure).
  - WAIT_LOW (ack=1):
    - If req_s=0: set ack<=0, go to IDLE.
    - No write occurs in this state.
- Capture:
  - Exactly one write per req rise, taken in the cycle IDLE sees req_s=1.
  - input_rx is guaranteed stable then by the bundling rule.
- Latency:
  - req rise to ack rise is SYNC_STAGES+1 clk edges, provided the FIFO is not full.
  - A captured word appears on output_rx, with d=1, the cycle after the capture edge when the FIFO was empty.
- Read side:
  - On rd=1 and d=1: rd_ptr+1 and count-1.
  - rd=1 with d=0 is ignored; no underflow and no pointer movement.
- Simultaneous write and read: count unchanged, both pointers advance.
- Full boundary:
  - The write decision uses the registered full flag.
  - A pop in the same cycle does not enable a write that cycle; the write happens on the next IDLE evaluation.
- Pointer arithmetic:
  - Pointers are clog2(DEPTH) bits and wrap modulo DEPTH naturally.
  - count is authoritative for full and empty (full = count==DEPTH, d = count!=0).
- Reset during WAIT_LOW:
  - ack drops to 0 and the FIFO is emptied.
  - If the sender's req is still high, a new capture occurs once req_s is seen high in IDLE. The sender must also reset to avoid a duplicate word.
- ack is never combinationally dependent on req; it is a pure FSM register output.

Decomposition:
- def.v (shared include) holds:
  - `DATA_WIDTHS
  - FSM state constants (IDLE, WAIT_LOW)
  - a clog2 function macro
- One sub-module, hs4_fifo:
  - Holds the storage array, pointers, count, full, d and show-ahead output_rx.
  - Inputs: push, pop, wdata.
- The top contains only the synchroniser, the FSM and the hs4_fifo instance.

Test Plan:
1. Reset asserted 3 cycles with req=1 -> ack=0, d=0, count=0 throughout reset. After release, ack rises exactly SYNC_STAGES+1 edges after req_s sampling begins.
2. Single transfer input_rx=8'hA5 -> ack rises at edge 3 after req rise (SYNC_STAGES=2); output_rx=8'hA5 and d=1 the next cycle. After req falls, ack falls 3 edges later.
3. Four back-to-back transfers 8'h01..8'h04 with rd=0 -> count=4, full=1. A 5th req (8'h05) gets no ack. Pulse rd once -> output_rx advances to 8'h02, then the 5th transfer is acked and 8'h05 is queued last.
4. FIFO empty, rd held at 1 for 5 cycles -> no change to count or pointers, d stays 0.
5. Streaming 16 words with rd=1 every cycle (simultaneous push and pop, pointer wrap past DEPTH) -> words read out in order 0..15, count never exceeds 1.
6. Reset asserted while in WAIT_LOW with 2 words queued -> next cycle ack=0, count=0, d=0, and no stale word appears on output_rx.

Source files
------------

// File: rtl/hs4_rx_fifo_pkg.sv
// Shared constants for the four-phase receive FIFO: default data width,
// FSM state encodings and a constant-evaluable ceil-log2 helper.
package hs4_rx_fifo_pkg;

  localparam int DATA_WIDTHS = 8;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_LOW = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hs4_fifo.sv
// Show-ahead FIFO. Every output (head word, valid, full, count) is a register
// that is loaded with its next-state value, so the consumer sees only flop outputs.
module hs4_fifo
  import hs4_rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTHS,
  parameter int DEPTH      = 4,
  localparam int AW        = clog2(DEPTH),
  localparam int CW        = clog2(DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_valid,
  output logic                  o_full,
  output logic [CW-1:0]         o_count
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_full;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_head;

  logic                  w_push;
  logic                  w_pop;
  logic [AW-1:0]         w_rd_nxt;
  logic [CW-1:0]         w_cnt_left;
  logic [CW-1:0]         w_cnt_nxt;
  logic [DATA_WIDTH-1:0] w_head_nxt;

  // Next-state bookkeeping; a push into a FIFO that is empty after this
  // cycle's pop bypasses storage straight into the head register.
  always_comb begin
    w_push     = i_push & ~r_full;
    w_pop      = i_pop & r_valid;
    w_rd_nxt   = w_pop ? r_rd_ptr + AW'(1'b1) : r_rd_ptr;
    w_cnt_left = w_pop ? r_count - CW'(1'b1) : r_count;
    w_cnt_nxt  = w_push ? w_cnt_left + CW'(1'b1) : w_cnt_left;
    if (w_cnt_nxt == '0) begin
      w_head_nxt = '0;
    end else if (w_push && (w_cnt_left == '0)) begin
      w_head_nxt = i_wdata;
    end else begin
      w_head_nxt = r_mem[w_rd_nxt];
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_valid  <= 1'b0;
      r_head   <= '0;
    end else begin
      r_wr_ptr <= w_push ? r_wr_ptr + AW'(1'b1) : r_wr_ptr;
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_cnt_nxt;
      r_full   <= (w_cnt_nxt == CW'(DEPTH));
      r_valid  <= (w_cnt_nxt != '0);
      r_head   <= w_head_nxt;
    end
  end

  assign o_rdata = r_head;
  assign o_valid = r_valid;
  assign o_full  = r_full;
  assign o_count = r_count;

endmodule

// File: rtl/hs4_rx_fifo.sv
// Receiver of the two-flop four-phase req/ack crossing: synchronises req,
// captures the bundled word once per request and queues it in hs4_fifo.
module hs4_rx_fifo
  import hs4_rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTHS,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  localparam int CW         = clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic [DATA_WIDTH-1:0] input_rx,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] output_rx,
  output logic                  d,
  input  logic                  rd,
  output logic                  full,
  output logic [CW-1:0]         count
);

  logic [SYNC_STAGES-1:0] r_sync;
  state_e                 r_state;
  logic                   r_ack;

  logic                   w_req_s;
  state_e                 w_state_nxt;
  logic                   w_ack_nxt;
  logic                   w_push;
  logic                   w_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], req};
    end
  end

  assign w_req_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  // Full is the registered flag, so a pop in this cycle frees a slot only for the next IDLE evaluation.
  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = r_ack;
    w_push      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req_s && !w_full) begin
          w_push      = 1'b1;
          w_ack_nxt   = 1'b1;
          w_state_nxt = ST_WAIT_LOW;
        end else begin
          w_ack_nxt = 1'b0;
        end
      end
      ST_WAIT_LOW: begin
        if (!w_req_s) begin
          w_ack_nxt   = 1'b0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_ack_nxt = 1'b1;
        end
      end
      default: begin
        w_ack_nxt   = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  hs4_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .i_clk  (clk),
    .i_reset(reset),
    .i_push (w_push),
    .i_pop  (rd),
    .i_wdata(input_rx),
    .o_rdata(output_rx),
    .o_valid(d),
    .o_full (w_full),
    .o_count(count)
  );

  assign full = w_full;
  assign ack  = r_ack;

endmodule

// File: tb/tb_hs4_rx_fifo.sv
// Directed and randomized bench for hs4_rx_fifo, checked every cycle against
// a queue-based model of the receiver.
module tb_hs4_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int SS    = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic          rd;
  logic [DW-1:0] input_rx;
  logic [DW-1:0] output_rx;
  logic          ack;
  logic          d;
  logic          full;
  logic [CW-1:0] count;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mq[$];
  logic          m_busy;
  logic          m_sync[SS];
  logic [DW-1:0] popped[$];
  bit            rec;
  int            max_cnt;
  int            n;

  always #5 clk = ~clk;

  hs4_rx_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .SYNC_STAGES(SS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .input_rx (input_rx),
    .ack      (ack),
    .output_rx(output_rx),
    .d        (d),
    .rd       (rd),
    .full     (full),
    .count    (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Receiver behaviour at one rising edge: req is seen SS edges late, one capture per request, no write when full.
  task automatic model_edge();
    logic rs;
    bit   do_pop;
    bit   do_push;
    if (reset) begin
      mq.delete();
      m_busy = 1'b0;
      for (int i = 0; i < SS; i++) m_sync[i] = 1'b0;
    end else begin
      rs      = m_sync[SS-1];
      do_pop  = rd && (mq.size() != 0);
      do_push = !m_busy && rs && (mq.size() < DEPTH);
      if (do_push) m_busy = 1'b1;
      else if (m_busy && !rs) m_busy = 1'b0;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(input_rx);
      for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = req;
    end
  endtask

  task automatic step();
    logic [DW-1:0] exp_head;
    if (rec && rd && d) popped.push_back(output_rx);
    @(posedge clk);
    model_edge();
    #1;
    exp_head = (mq.size() != 0) ? mq[0] : '0;
    check("ack", ack, m_busy);
    check("d", d, mq.size() != 0);
    check("count", count, mq.size());
    check("full", full, mq.size() == DEPTH);
    check("output_rx", output_rx, exp_head);
    if (int'(count) > max_cnt) max_cnt = int'(count);
  endtask

  task automatic wait_ack(input logic val, output int cycles);
    cycles = 0;
    while (ack !== val && cycles < 40) begin
      step();
      cycles++;
    end
    check("ack_wait", ack, val);
  endtask

  task automatic send_word(input logic [DW-1:0] data);
    int c;
    input_rx = data;
    req      = 1'b1;
    wait_ack(1'b1, c);
    req = 1'b0;
    wait_ack(1'b0, c);
  endtask

  initial begin
    rec      = 1'b0;
    max_cnt  = 0;
    m_busy   = 1'b0;
    for (int i = 0; i < SS; i++) m_sync[i] = 1'b0;
    reset    = 1'b1;
    req      = 1'b1;
    rd       = 1'b0;
    input_rx = DW'($urandom);

    // 1: reset held with req high, then release latency
    repeat (3) step();
    check("rst_ack", ack, 1'b0);
    check("rst_count", count, 0);
    reset = 1'b0;
    wait_ack(1'b1, n);
    check("rst_rel_lat", n, SS + 1);
    req = 1'b0;
    wait_ack(1'b0, n);
    rd = 1'b1;
    step();
    rd = 1'b0;
    step();

    // 2: single transfer A5 and both ack latencies
    input_rx = 8'hA5;
    req      = 1'b1;
    wait_ack(1'b1, n);
    check("lat_rise", n, SS + 1);
    step();
    check("single_head", output_rx, 8'hA5);
    check("single_d", d, 1'b1);
    req = 1'b0;
    wait_ack(1'b0, n);
    check("lat_fall", n, SS + 1);
    rd = 1'b1;
    step();
    rd = 1'b0;

    // 3: fill to full, backpressure, pop releases the fifth word
    for (int i = 1; i <= 4; i++) send_word(DW'(i));
    check("fill_count", count, 4);
    check("fill_full", full, 1'b1);
    input_rx = 8'h05;
    req      = 1'b1;
    repeat (8) step();
    check("no_ack_full", ack, 1'b0);
    rd = 1'b1;
    step();
    rd = 1'b0;
    check("head_after_pop", output_rx, 8'h02);
    wait_ack(1'b1, n);
    req = 1'b0;
    wait_ack(1'b0, n);
    check("refill_count", count, 4);
    rd = 1'b1;
    repeat (3) step();
    check("last_word", output_rx, 8'h05);
    step();

    // 4: reads on an empty FIFO are ignored
    repeat (5) step();
    check("empty_d", d, 1'b0);
    check("empty_count", count, 0);

    // 5: streaming with rd held high, pointer wrap
    rec     = 1'b1;
    max_cnt = 0;
    popped.delete();
    for (int i = 0; i < 16; i++) send_word(DW'(i));
    repeat (3) step();
    rec = 1'b0;
    check("stream_len", popped.size(), 16);
    for (int i = 0; i < 16 && i < popped.size(); i++) check("stream_order", popped[i], i);
    check("stream_maxcnt", max_cnt <= 1, 1'b1);

    // 6: reset while in WAIT_LOW with two words queued
    rd = 1'b0;
    send_word(DW'($urandom));
    input_rx = DW'($urandom);
    req      = 1'b1;
    wait_ack(1'b1, n);
    check("pre_rst_count", count, 2);
    reset = 1'b1;
    step();
    check("wl_rst_ack", ack, 1'b0);
    check("wl_rst_count", count, 0);
    check("wl_rst_d", d, 1'b0);
    check("wl_rst_head", output_rx, 0);
    req   = 1'b0;
    reset = 1'b0;
    repeat (5) step();
    check("post_rst_d", d, 1'b0);

    // randomized traffic with random read enable and idle gaps
    for (int k = 0; k < 24; k++) begin
      rd = 1'($urandom_range(0, 1));
      send_word(DW'($urandom));
      repeat ($urandom_range(0, 3)) step();
    end
    rd = 1'b1;
    repeat (6) step();
    check("drain_d", d, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
